// File: rtl/sort4_ctrl.sv
// sort4_ctrl: sequential bubble sort of four signed 4-bit elements.
// One shared magnitude comparator; six fixed compare cycles per sort.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - async active-low reset
//   start    - sort request, sampled in IDLE only
//   din      - four signed elements, element i = din[4i+3:4i]
//   busy     - high while compares are in progress (CMP)
//   done     - one-cycle pulse, dout/swap_cnt valid
//   dout     - sorted ascending, dout[3:0] = smallest
//   swap_cnt - swaps performed by the last completed sort

module cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       agtb,
    output logic       aeqb,
    output logic       altb
);
    assign agtb = (a > b);
    assign aeqb = (a == b);
    assign altb = (a < b);
endmodule

module sort4_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [2:0]  swap_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] r    [4];
    logic [3:0] r_nx [4];
    logic [1:0] pass, pass_nx;
    logic [1:0] idx, idx_nx;
    logic [1:0] idx1;
    logic [2:0] wcnt, wcnt_nx;
    logic [3:0] op_a, op_b;
    logic       agtb, aeqb, altb;
    logic       swap;
    logic       last;

    assign idx1 = idx + 2'd1;

    // Flipping the sign bit maps signed order onto unsigned order.
    assign op_a = {~r[idx][3],  r[idx][2:0]};
    assign op_b = {~r[idx1][3], r[idx1][2:0]};

    cmp4 u_cmp (
        .a    (op_a),
        .b    (op_b),
        .agtb (agtb),
        .aeqb (aeqb),
        .altb (altb)
    );

    // Swap only on strictly greater; equal keeps order (stable).
    assign swap = agtb && !aeqb && !altb;
    assign last = (state == CMP) && (pass == 2'd2) && (idx == 2'd0);

    always_comb begin
        state_nx = state;
        r_nx     = r;
        pass_nx  = pass;
        idx_nx   = idx;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 4; i++) begin
                        r_nx[i] = din[4*i +: 4];
                    end
                    wcnt_nx  = 3'd0;
                    pass_nx  = 2'd0;
                    idx_nx   = 2'd0;
                    state_nx = CMP;
                end
            end
            CMP: begin
                if (swap) begin
                    r_nx[idx]  = r[idx1];
                    r_nx[idx1] = r[idx];
                    wcnt_nx    = wcnt + 3'd1;
                end
                // Pass p compares idx 0 .. 2-p.
                if (last) begin
                    pass_nx  = 2'd0;
                    idx_nx   = 2'd0;
                    state_nx = DONE;
                end else if (idx == (2'd2 - pass)) begin
                    pass_nx = pass + 2'd1;
                    idx_nx  = 2'd0;
                end else begin
                    idx_nx = idx + 2'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pass     <= 2'd0;
            idx      <= 2'd0;
            wcnt     <= 3'd0;
            dout     <= 16'h0000;
            swap_cnt <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r[i] <= 4'd0;
            end
        end else begin
            state <= state_nx;
            pass  <= pass_nx;
            idx   <= idx_nx;
            wcnt  <= wcnt_nx;
            r     <= r_nx;
            if (last) begin
                dout     <= {r_nx[3], r_nx[2], r_nx[1], r_nx[0]};
                swap_cnt <= wcnt_nx;
            end
        end
    end

    assign busy = (state == CMP);
    assign done = (state == DONE);
endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: table vectors, random vectors against a rank-based
// reference model, plus start-held and mid-sort reset sequences.

module tb_sort4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sort4_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic [2:0]  cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Stable rank placement; swap count of bubble sort = inversion count.
    function automatic void model(input logic [15:0] d,
                                  output logic [15:0] s,
                                  output logic [2:0] n);
        int a[4];
        int rk;
        int inv;
        s   = '0;
        inv = 0;
        for (int i = 0; i < 4; i++) a[i] = int'($signed(d[4*i +: 4]));
        for (int i = 0; i < 4; i++) begin
            rk = 0;
            for (int j = 0; j < 4; j++) begin
                if (a[j] < a[i] || (a[j] == a[i] && j < i)) rk++;
                if (j > i && a[j] < a[i]) inv++;
            end
            s[4*rk +: 4] = d[4*i +: 4];
        end
        n = 3'(inv);
    endfunction

    // Call at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic do_sort(input logic [15:0] d,
                           output logic [15:0] od,
                           output logic [2:0] oc);
        start = 1'b1;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
        for (int k = 0; k < 6; k++) begin
            chk("busy_cmp", busy, 1);
            chk("done_early", done, 0);
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        od = dout;
        oc = swap_cnt;
        @(negedge clk);
        chk("done_once", done, 0);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [15:0] od, ed, sa, sb, sc, a_v, b_v, c_v;
        logic [2:0]  oc, ec, na, nb, nc;
        bit          exp_done;

        tbl[0] = '{16'h8F27, 16'h72F8, 3'd6};
        tbl[1] = '{16'h52B8, 16'h52B8, 3'd0};
        tbl[2] = '{16'h3333, 16'h3333, 3'd0};
        tbl[3] = '{16'hF5F5, 16'h55FF, 3'd3};
        tbl[4] = '{16'h0000, 16'h0000, 3'd0};
        tbl[5] = '{16'h7F80, 16'h70F8, 3'd2};
        tbl[6] = '{16'h0123, 16'h3210, 3'd6};

        rst_n = 1'b0;
        start = 1'b1;
        din   = 16'h8F27;
        repeat (4) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_dout", dout, 16'h0000);
            chk("rst_cnt", swap_cnt, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_sort(tbl[i].din, od, oc);
            chk("tbl_dout", od, tbl[i].dout);
            chk("tbl_cnt", oc, tbl[i].cnt);
            repeat (2) @(negedge clk);
            chk("hold_dout", dout, tbl[i].dout);
            chk("hold_cnt", swap_cnt, tbl[i].cnt);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            model(d, ed, ec);
            do_sort(d, od, oc);
            chk("rnd_dout", od, ed);
            chk("rnd_cnt", oc, ec);
        end

        a_v = 16'h8F27;
        b_v = 16'h1E9C;
        c_v = 16'hF5F5;
        model(a_v, sa, na);
        model(b_v, sb, nb);
        model(c_v, sc, nc);
        start = 1'b1;
        din   = a_v;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1)  din = b_v;
            if (c == 10) din = c_v;
            if (c == 16) start = 1'b0;
            exp_done = (c == 6) || (c == 14) || (c == 22);
            chk("held_done", done, exp_done);
            if (c == 6) begin
                chk("held1_dout", dout, sa);
                chk("held1_cnt", swap_cnt, na);
            end
            if (c == 14) begin
                chk("held2_dout", dout, sb);
                chk("held2_cnt", swap_cnt, nb);
            end
            if (c == 22) begin
                chk("held3_dout", dout, sc);
                chk("held3_cnt", swap_cnt, nc);
            end
        end

        start = 1'b1;
        din   = 16'h0123;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout", dout, 16'h0000);
        chk("abort_cnt", swap_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        do_sort(16'h8F27, od, oc);
        chk("post_rst_dout", od, 16'h72F8);
        chk("post_rst_cnt", oc, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
